cci_mpf_prim_fifo_packer: RTL and testbench
===========================================

Name: cci_mpf_prim_fifo_packer

Overview:
Downstream consumer of the LUTRAM FIFO read port (first/notEmpty/deq_en). It pops narrow FIFO entries and packs N_BEATS of them into one wide word, LSB lane first, and presents that word through a registered output slot.
- Partial words are emitted on an idle timeout or on an explicit flush, with a beat count attached.
- Typical use: gathering header/metadata entries into a single wide write toward CCI.

Parameters:
N_DATA_BITS, 32, width of one FIFO entry (one lane).
N_BEATS, 4, lanes per packed word; must be >= 2; need not be a power of two.
TIMEOUT_CYCLES, 16, idle cycles before a partial word is promoted; 0 disables the timeout.

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
in_first  input  N_DATA_BITS  FIFO head data.
in_notEmpty  input  1  FIFO head valid.
in_deq  output  1  pop FIFO head this cycle (drives FIFO deq_en).
flush_req  input  1  level; promote the current partial word.
out_data  output  N_BEATS*N_DATA_BITS  packed word; lane k at bits [k*N_DATA_BITS +: N_DATA_BITS].
out_cnt  output  $clog2(N_BEATS+1)  valid lanes in out_data (1..N_BEATS).
out_valid  output  1  output slot holds a word.
out_deq  input  1  consumer takes out_data this cycle.

Behaviour:
- Interface: clock clk; reset reset, synchronous, active-high.
- State:
  - asm_data / asm_cnt: assembly register, asm_cnt in 0..N_BEATS.
  - idle_cnt: idle-cycle counter, saturates at TIMEOUT_CYCLES.
  - out_data / out_cnt / out_valid: output slot.
- Reset values: asm_cnt=0, asm_data=0, idle_cnt=0, out_valid=0, out_data=0, out_cnt=0. in_deq is forced to 0 while reset is high.
- Derived signals:
  - out_free = !out_valid || out_deq.
  - timeout_hit = (TIMEOUT_CYCLES != 0) && (idle_cnt == TIMEOUT_CYCLES).
  - promote = out_free && ((asm_cnt == N_BEATS) || (asm_cnt != 0 && (timeout_hit || flush_req))).
  - in_deq = in_notEmpty && (asm_cnt != N_BEATS || promote) && !reset. This is combinational from in_notEmpty, out_deq and flush_req.
- Beat accept (in_deq=1):
  - Without promote: in_first is written into lane asm_cnt and asm_cnt increments.
  - With promote in the same cycle: the old assembly moves to the output slot; in_first goes to lane 0 of a cleared asm_data and asm_cnt becomes 1. A beat arriving with a timeout/flush promote always starts the new word.
- Promote:
  - out_data<=asm_data, out_cnt<=asm_cnt, out_valid<=1.
  - asm_data cleared, so unused lanes of a partial word are zero.
  - asm_cnt<=0, or 1 if a beat is accepted in the same cycle.
- Output slot: out_deq && !promote clears out_valid. out_deq with out_valid=0 is illegal: fatal assertion in simulation, no state change.
- Latency:
  - The beat completing a word, accepted in cycle t, gives out_valid at t+2 if the slot is free.
  - Steady-state throughput with out_deq held high is one beat per cycle, no bubbles.
- Timeout:
  - idle_cnt resets to 0 on any accept or promote, and whenever asm_cnt==0.
  - Otherwise it increments each cycle while 0 < asm_cnt < N_BEATS, saturating.
  - With last accept in cycle t and no further input, promote occurs in cycle t+1+TIMEOUT_CYCLES (if out_free) and out_valid appears one cycle later.
- flush_req with asm_cnt==0 has no effect; empty words are never emitted.
- Backpressure: with asm full and the slot occupied, in_deq=0 and the FIFO retains data. No beat is lost or reordered, and the word order at the output is strict FIFO order.
- Reset mid-operation discards both the partial assembly and the output word.

Test Plan:
- Reset, using N_DATA_BITS=8, N_BEATS=4, TIMEOUT_CYCLES=4 (also used for all scenarios below): hold reset with in_notEmpty=1 -> in_deq=0 and out_valid=0 throughout; the first cycle after reset gives in_deq=1.
- Full pack: 0x11,0x22,0x33,0x44 accepted in cycles 0-3, out_deq=1 -> out_valid in cycle 5 with out_data=0x44332211 and out_cnt=4, held one cycle; a fifth beat 0x55 lands in lane 0 of the next word.
- Timeout: accept 0xA1 and 0xA2 in cycles 0-1, then in_notEmpty=0 -> promote in cycle 6, out_valid in cycle 7 with out_data=0x0000A2A1 and out_cnt=2. With TIMEOUT_CYCLES=0 nothing is emitted.
- Backpressure: out_deq=0 while 12 beats 0x01..0x0C are offered -> the first word is held and the second assembles to asm_cnt=4; in_deq drops to 0 with 4 beats still in the FIFO. Raising out_deq gives words 0x04030201, 0x08070605, 0x0C0B0A09 in order with no loss.
- Flush: flush_req=1 with asm_cnt=0 -> no output. One beat 0x7E then flush_req=1 -> out_data=0x0000007E, out_cnt=1. A flush coinciding with a beat 0x7F puts 0x7F in lane 0 of the next word.
- Reset mid-op: asm_cnt=3 and out_valid=1, assert reset one cycle -> all state cleared; the next beats 0x21..0x24 produce out_data=0x24232221.

Source files
------------

// File: rtl/cci_mpf_prim_fifo_packer.sv
// ============================================================================
// cci_mpf_prim_fifo_packer
//
// Purpose:
//   Sits on the read side of a LUTRAM FIFO (first / notEmpty / deq_en) and
//   packs N_BEATS narrow entries into one wide word, lane 0 first. The packed
//   word is handed to the consumer through a single registered output slot.
//   A partial word is emitted when no new beat has arrived for
//   TIMEOUT_CYCLES cycles, or when flush_req is raised. Every emitted word
//   carries a count of its valid lanes. Lanes above that count are zero.
//
// Parameters:
//   N_DATA_BITS    - width of one FIFO entry (one lane).
//   N_BEATS        - lanes per packed word. Must be at least 2. Any value is
//                    allowed, not only powers of two.
//   TIMEOUT_CYCLES - idle cycles before a partial word is promoted.
//                    0 turns the timeout off.
//
// Ports:
//   clk          clock.
//   reset        synchronous, active-high reset.
//   in_first     FIFO head data.
//   in_notEmpty  FIFO head valid.
//   in_deq       pop the FIFO head this cycle (combinational).
//   flush_req    level. Promote the current partial word.
//   out_data     packed word. Lane k is at [k*N_DATA_BITS +: N_DATA_BITS].
//   out_cnt      number of valid lanes in out_data (1..N_BEATS).
//   out_valid    the output slot holds a word.
//   out_deq      the consumer takes out_data this cycle.
// ============================================================================
module cci_mpf_prim_fifo_packer #(
    parameter int N_DATA_BITS    = 32,
    parameter int N_BEATS        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                               clk,
    input  logic                               reset,

    input  logic [N_DATA_BITS-1:0]             in_first,
    input  logic                               in_notEmpty,
    output logic                               in_deq,

    input  logic                               flush_req,

    output logic [N_BEATS*N_DATA_BITS-1:0]     out_data,
    output logic [$clog2(N_BEATS+1)-1:0]       out_cnt,
    output logic                               out_valid,
    input  logic                               out_deq
);

    localparam int CNT_W  = $clog2(N_BEATS + 1);
    // The idle counter must hold the value TIMEOUT_CYCLES. When the timeout
    // is disabled, the counter is kept at one bit and stays at zero.
    localparam int IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(N_BEATS);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]                   asm_cnt_reg;
    logic [CNT_W-1:0]                   asm_cnt_next;
    logic [IDLE_W-1:0]                  idle_cnt_reg;
    logic [IDLE_W-1:0]                  idle_cnt_next;

    logic [N_BEATS*N_DATA_BITS-1:0]     out_data_reg;
    logic [N_BEATS*N_DATA_BITS-1:0]     out_data_next;
    logic [CNT_W-1:0]                   out_cnt_reg;
    logic [CNT_W-1:0]                   out_cnt_next;
    logic                               out_valid_reg;
    logic                               out_valid_next;

    // Flat view of the assembly lanes. The lanes are held in per-lane
    // registers inside the generate loop below.
    logic [N_BEATS*N_DATA_BITS-1:0]     asm_flat;

    // ------------------------------------------------------------------
    // Control decisions
    // ------------------------------------------------------------------
    logic out_free;
    logic asm_full;
    logic asm_empty;
    logic timeout_hit;
    logic promote;
    logic accept;

    // The slot can take a new word when it is empty, or when it is drained
    // in this same cycle. This lets full words stream out with no bubbles.
    assign out_free    = !out_valid_reg || out_deq;
    assign asm_full    = (asm_cnt_reg == CNT_FULL);
    assign asm_empty   = (asm_cnt_reg == '0);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (idle_cnt_reg == IDLE_MAX);

    // A full assembly always moves on as soon as the slot is free. A partial
    // assembly moves on only on timeout or flush. An empty assembly never
    // moves, so empty words are never produced.
    assign promote = out_free &&
                     (asm_full || (!asm_empty && (timeout_hit || flush_req)));

    // A beat is accepted when there is room for it. Room means a lane is
    // still open, or the assembly is leaving this cycle and the beat takes
    // lane 0 of the fresh word.
    assign accept = in_notEmpty && (!asm_full || promote) && !reset;
    assign in_deq = accept;

    // ------------------------------------------------------------------
    // Assembly lanes
    // ------------------------------------------------------------------
    // Each lane has its own write enable. On a promote, the incoming beat
    // (if any) goes to lane 0 and every other lane is cleared. This keeps
    // unused lanes of a later partial word at zero. Without a promote, the
    // beat goes to the lane indexed by asm_cnt_reg.
    genvar gi;
    generate
        for (gi = 0; gi < N_BEATS; gi++) begin : g_lane
            logic [N_DATA_BITS-1:0] lane_reg;
            logic                   lane_hit;

            assign lane_hit = accept &&
                              (promote ? (gi == 0) : (asm_cnt_reg == CNT_W'(gi)));

            always_ff @(posedge clk) begin
                if (reset) begin
                    lane_reg <= '0;
                end else if (lane_hit) begin
                    lane_reg <= in_first;
                end else if (promote) begin
                    lane_reg <= '0;
                end
            end

            assign asm_flat[gi*N_DATA_BITS +: N_DATA_BITS] = lane_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic for the counters and the output slot
    // ------------------------------------------------------------------
    always_comb begin
        asm_cnt_next = asm_cnt_reg;
        if (promote) begin
            asm_cnt_next = accept ? CNT_ONE : '0;
        end else if (accept) begin
            asm_cnt_next = asm_cnt_reg + CNT_ONE;
        end
    end

    // The idle counter measures how long a partial word has waited with no
    // new input. It restarts on every accept or promote, and it is held at
    // zero while nothing is being assembled. It saturates at
    // TIMEOUT_CYCLES. If the slot is busy when the timeout fires, the
    // promote simply waits until the slot frees up.
    always_comb begin
        idle_cnt_next = idle_cnt_reg;
        if (accept || promote || asm_empty) begin
            idle_cnt_next = '0;
        end else if (!asm_full && (idle_cnt_reg != IDLE_MAX)) begin
            idle_cnt_next = idle_cnt_reg + IDLE_ONE;
        end
    end

    always_comb begin
        out_data_next  = out_data_reg;
        out_cnt_next   = out_cnt_reg;
        out_valid_next = out_valid_reg;
        if (promote) begin
            out_data_next  = asm_flat;
            out_cnt_next   = asm_cnt_reg;
            out_valid_next = 1'b1;
        end else if (out_deq) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            asm_cnt_reg   <= '0;
            idle_cnt_reg  <= '0;
            out_data_reg  <= '0;
            out_cnt_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            asm_cnt_reg   <= asm_cnt_next;
            idle_cnt_reg  <= idle_cnt_next;
            out_data_reg  <= out_data_next;
            out_cnt_reg   <= out_cnt_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign out_data  = out_data_reg;
    assign out_cnt   = out_cnt_reg;
    assign out_valid = out_valid_reg;

    // Draining an empty slot means the consumer has lost track of the
    // handshake. The datapath ignores it, because out_valid is already low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(out_deq && !out_valid_reg))
                else $fatal(1, "cci_mpf_prim_fifo_packer: out_deq asserted with empty output slot");
        end
    end

endmodule

// File: tb/tb_cci_mpf_prim_fifo_packer.sv
// ============================================================================
// tb_cci_mpf_prim_fifo_packer
//
// Bench for cci_mpf_prim_fifo_packer (8-bit lanes, 4 lanes, timeout 4).
// The bench acts as the upstream FIFO itself, using a queue. Each beat
// popped from the queue is appended to a sent-order queue. Each word the
// consumer takes is split into lanes, and the lanes are matched against
// that order. Lanes above out_cnt must be zero. Directed steps check the
// exact cycle timing and word values for the main scenarios. A second
// instance with the timeout disabled checks that partial words are only
// emitted on a flush.
// ============================================================================
module tb_cci_mpf_prim_fifo_packer;

    localparam int DW = 8;
    localparam int NB = 4;
    localparam int TO = 4;
    localparam int OW = DW * NB;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_first;
    logic          in_notEmpty;
    logic          in_deq;
    logic          flush_req;
    logic [OW-1:0] out_data;
    logic [2:0]    out_cnt;
    logic          out_valid;
    logic          out_deq;

    // Instance with the timeout disabled
    logic [DW-1:0] in_first_z;
    logic          in_notEmpty_z;
    logic          in_deq_z;
    logic          flush_z;
    logic [OW-1:0] out_data_z;
    logic [2:0]    out_cnt_z;
    logic          out_valid_z;
    logic          out_deq_z;

    always #5 clk = ~clk;

    cci_mpf_prim_fifo_packer #(
        .N_DATA_BITS(DW), .N_BEATS(NB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .in_first(in_first), .in_notEmpty(in_notEmpty), .in_deq(in_deq),
        .flush_req(flush_req),
        .out_data(out_data), .out_cnt(out_cnt), .out_valid(out_valid),
        .out_deq(out_deq)
    );

    cci_mpf_prim_fifo_packer #(
        .N_DATA_BITS(DW), .N_BEATS(NB), .TIMEOUT_CYCLES(0)
    ) dut_noto (
        .clk(clk), .reset(reset),
        .in_first(in_first_z), .in_notEmpty(in_notEmpty_z), .in_deq(in_deq_z),
        .flush_req(flush_z),
        .out_data(out_data_z), .out_cnt(out_cnt_z), .out_valid(out_valid_z),
        .out_deq(out_deq_z)
    );

    int checks   = 0;
    int failures = 0;
    int words    = 0;

    logic [DW-1:0] fifo_q[$];   // upstream FIFO contents
    logic [DW-1:0] sent_q[$];   // beats popped, not yet seen at the output
    logic          fifo_en;
    logic          consume;
    logic          rand_mode;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        in_notEmpty = fifo_en && (fifo_q.size() != 0);
        in_first    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic push(input logic [DW-1:0] v);
        fifo_q.push_back(v);
        drive_fifo();
    endtask

    // One output word is taken by the consumer. Check each lane against
    // FIFO order.
    task automatic score_word();
        logic [DW-1:0] lane;
        logic [DW-1:0] exp;
        words++;
        $display("word %0d: data=0x%08h cnt=%0d", words, out_data, out_cnt);
        chk("cnt_range", 64'(out_cnt >= 3'd1 && out_cnt <= 3'(NB)), 64'd1);
        for (int k = 0; k < NB; k++) begin
            lane = out_data[k*DW +: DW];
            if (k < int'(out_cnt)) begin
                chk("lane_src_avail", 64'(sent_q.size() != 0), 64'd1);
                if (sent_q.size() != 0) begin
                    exp = sent_q.pop_front();
                    chk("lane_order", lane, exp);
                end
            end else begin
                chk("lane_pad_zero", lane, 64'd0);
            end
        end
    endtask

    // Advance one clock. Sample at the negedge, then drive new inputs
    // just after the posedge.
    task automatic cyc();
        logic took;
        @(negedge clk);
        took = in_deq;
        if (out_valid && out_deq) score_word();
        @(posedge clk);
        #1;
        if (took) begin
            chk("deq_nonempty", 64'(fifo_q.size() != 0), 64'd1);
            if (fifo_q.size() != 0) sent_q.push_back(fifo_q.pop_front());
        end
        if (rand_mode) begin
            fifo_en   = ($urandom_range(0, 3) != 0);
            flush_req = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 1) fifo_q.push_back(8'($urandom));
            out_deq   = out_valid && ($urandom_range(0, 3) != 0);
        end else begin
            out_deq = consume && out_valid;
        end
        drive_fifo();
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int words_before;
        reset = 1'b1; flush_req = 1'b0; out_deq = 1'b0;
        fifo_en = 1'b1; consume = 1'b0; rand_mode = 1'b0;
        in_first_z = '0; in_notEmpty_z = 1'b0; flush_z = 1'b0; out_deq_z = 1'b0;
        push(8'h5A);

        // Reset held with the FIFO non-empty
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            chk("rst_in_deq", in_deq, 0);
            chk("rst_out_valid", out_valid, 0);
        end
        chk("rst_out_data", out_data, 0);
        chk("rst_out_cnt", out_cnt, 0);
        @(posedge clk); #1;
        reset = 1'b0; consume = 1'b1;
        #1;
        chk("post_rst_in_deq", in_deq, 1);
        // Single beat accepted in cycle 0 times out: promote at 5, valid at 6
        cycn(5);
        chk("single_to_c5_valid", out_valid, 0);
        cyc();
        chk("single_to_valid", out_valid, 1);
        chk("single_to_data", out_data, 32'h0000005A);
        chk("single_to_cnt", out_cnt, 1);
        cyc();

        // Full pack
        push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
        #1;
        chk("pack_c0_in_deq", in_deq, 1);
        cycn(4);
        chk("pack_c4_valid", out_valid, 0);
        chk("pack_c4_in_deq", in_deq, 1);
        cyc();
        chk("pack_valid", out_valid, 1);
        chk("pack_data", out_data, 32'h44332211);
        chk("pack_cnt", out_cnt, 4);
        cyc();
        chk("pack_c6_valid", out_valid, 0);
        cycn(3);
        chk("pack55_c9_valid", out_valid, 0);
        cyc();
        chk("pack55_valid", out_valid, 1);
        chk("pack55_data", out_data, 32'h00000055);
        chk("pack55_cnt", out_cnt, 1);
        cyc();

        // Timeout, plus the same traffic into the instance without a timeout
        push(8'hA1); push(8'hA2);
        in_notEmpty_z = 1'b1; in_first_z = 8'hB1;
        #1;
        chk("to_c0_in_deq", in_deq, 1);
        chk("noto_c0_in_deq", in_deq_z, 1);
        cyc();
        in_first_z = 8'hB2;
        cyc();
        in_notEmpty_z = 1'b0; in_first_z = '0;
        cycn(4);
        chk("to_c6_valid", out_valid, 0);
        cyc();
        chk("to_valid", out_valid, 1);
        chk("to_data", out_data, 32'h0000A2A1);
        chk("to_cnt", out_cnt, 2);
        cycn(10);
        chk("noto_no_output", out_valid_z, 0);
        flush_z = 1'b1;
        cyc();
        flush_z = 1'b0;
        #1;
        chk("noto_flush_valid", out_valid_z, 1);
        chk("noto_flush_data", out_data_z, 32'h0000B2B1);
        chk("noto_flush_cnt", out_cnt_z, 2);
        cyc();

        // Backpressure
        consume = 1'b0;
        for (int v = 1; v <= 12; v++) push(8'(v));
        cycn(8);
        chk("bp_c8_in_deq", in_deq, 0);
        chk("bp_c8_valid", out_valid, 1);
        chk("bp_c8_data", out_data, 32'h04030201);
        chk("bp_c8_fifo_left", fifo_q.size(), 4);
        cyc();
        chk("bp_c9_in_deq", in_deq, 0);
        chk("bp_c9_fifo_left", fifo_q.size(), 4);
        cyc();
        consume = 1'b1; out_deq = out_valid;
        #1;
        chk("bp_release_in_deq", in_deq, 1);
        cyc();
        chk("bp_w2_valid", out_valid, 1);
        chk("bp_w2_data", out_data, 32'h08070605);
        cycn(4);
        chk("bp_w3_valid", out_valid, 1);
        chk("bp_w3_data", out_data, 32'h0C0B0A09);
        chk("bp_w3_cnt", out_cnt, 4);
        cyc();

        // Flush
        flush_req = 1'b1;
        cycn(2);
        chk("flush_empty_no_out", out_valid, 0);
        flush_req = 1'b0;
        push(8'h7E);
        cyc();
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        #1;
        chk("flush1_valid", out_valid, 1);
        chk("flush1_data", out_data, 32'h0000007E);
        chk("flush1_cnt", out_cnt, 1);
        push(8'h70); push(8'h7F);
        cyc();
        flush_req = 1'b1;
        #1;
        chk("flush_beat_in_deq", in_deq, 1);
        cyc();
        flush_req = 1'b0;
        #1;
        chk("flush70_data", out_data, 32'h00000070);
        cyc();
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        #1;
        chk("flush7f_valid", out_valid, 1);
        chk("flush7f_data", out_data, 32'h0000007F);
        chk("flush7f_cnt", out_cnt, 1);
        cyc();

        // Reset in the middle of operation
        consume = 1'b0;
        for (int v = 8'h31; v <= 8'h37; v++) push(8'(v));
        cycn(7);
        chk("midop_pre_valid", out_valid, 1);
        reset = 1'b1;
        push(8'h21); push(8'h22); push(8'h23); push(8'h24);
        #1;
        chk("midop_rst_in_deq", in_deq, 0);
        cyc();
        reset = 1'b0;
        sent_q.delete();
        consume = 1'b1;
        #1;
        chk("midop_valid_clr", out_valid, 0);
        chk("midop_data_clr", out_data, 0);
        chk("midop_cnt_clr", out_cnt, 0);
        chk("midop_noto_clr", out_valid_z, 0);
        chk("midop_in_deq", in_deq, 1);
        cycn(5);
        chk("midop_word_valid", out_valid, 1);
        chk("midop_word_data", out_data, 32'h24232221);
        chk("midop_word_cnt", out_cnt, 4);
        cyc();

        // Randomized traffic, checked by the scoreboard
        words_before = words;
        rand_mode = 1'b1;
        cycn(600);
        rand_mode = 1'b0;
        fifo_en = 1'b1; consume = 1'b1; flush_req = 1'b1;
        for (int i = 0; i < 300 && !(fifo_q.size() == 0 && sent_q.size() == 0); i++) cyc();
        flush_req = 1'b0;
        chk("drain_fifo_empty", fifo_q.size(), 0);
        chk("drain_all_emitted", sent_q.size(), 0);
        chk("rand_words_seen", 64'(words > words_before + 20), 64'd1);
        cycn(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
